mul_repadd: RTL and testbench

//  Sequential unsigned multiplier using repeated addition, the inverse of the divider
//    (repeated subtraction) in the same arithmetic block set.

---
 rtl/mul_repadd_if.sv | 23 ++
 rtl/mul_repadd.sv | 89 ++++++++
 tb/tb_mul_repadd.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mul_repadd_if.sv
// Handshake and operand bundle between the top-level sequencer and the
// repeated-addition multiplier. The sequencer owns start/a/b and the
// multiplier answers with busy/done/product.
interface mul_repadd_if #(
   parameter int WIDTH = 8
);
   logic                 start;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output start, a, b,
      input  busy, done, product
   );

   modport slave (
      input  start, a, b,
      output busy, done, product
   );
endinterface

// File: rtl/mul_repadd.sv
// Sequential unsigned multiplier built from repeated addition, the mirror
// image of the repeated-subtraction divider. A start seen in IDLE latches
// a and b; a is then added into an accumulator b times and the sum is
// published on product together with a one-cycle done pulse. The product
// register keeps the previous result until the next operation finishes, so
// the sequencer can read it at any time.
module mul_repadd #(
   parameter int WIDTH = 8
) (
   input  logic         clk,
   input  logic         clear,
   mul_repadd_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ADD  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     areg_q, areg_d;
   logic [WIDTH-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   product_q, product_d;

   // State and datapath registers; clear drops everything to zero at once so an in-flight operation simply vanishes.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state_q   <= IDLE;
         areg_q    <= '0;
         cnt_q     <= '0;
         acc_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         areg_q    <= areg_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         product_q <= product_d;
      end
   end

   // Next-state and datapath updates; cnt counts remaining additions, so an ADD with cnt at zero publishes the sum instead of adding.
   always_comb begin
      state_d   = state_q;
      areg_d    = areg_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      product_d = product_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               areg_d  = bus.a;
               cnt_d   = bus.b;
               state_d = LOAD;
            end
         end
         LOAD: begin
            acc_d   = '0;
            state_d = ADD;
         end
         ADD: begin
            if (cnt_q == '0) begin
               product_d = acc_q;
               state_d   = DONE;
            end else begin
               acc_d = acc_q + {{WIDTH{1'b0}}, areg_q};
               cnt_d = cnt_q - WIDTH'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Status flags come straight from the registered state, so they never glitch.
   always_comb begin
      bus.busy    = (state_q == LOAD) || (state_q == ADD);
      bus.done    = (state_q == DONE);
      bus.product = product_q;
   end

endmodule

// File: tb/tb_mul_repadd.sv
// Self-checking bench for the repeated-addition multiplier: a table of
// directed operands, randomized operands compared against plain a*b and a
// latency of b+3, plus hand-written sequences for clear during an
// operation and for start arriving while busy.
module tb_mul_repadd;

   localparam int WIDTH = 8;

   logic clk;
   logic clear;
   int   total_cnt;
   int   bad_cnt;

   mul_repadd_if #(.WIDTH(WIDTH)) bus ();

   mul_repadd #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .clear (clear),
      .bus   (bus)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] exp_product;
      int          exp_latency;
   } vec_t;

   vec_t vecs [7];

   task automatic check_output(input string name, input longint actual, input longint expected);
      total_cnt++;
      if (actual != expected) begin
         bad_cnt++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Runs one full operation: start for one cycle, then scramble a/b and
   // watch cycles (numbered from 1 after the accepting edge) until done.
   task automatic apply_stimulus(input logic [7:0] a_in, input logic [7:0] b_in,
                                 output int lat, output int busy_cyc,
                                 output logic hold_ok, output logic [15:0] prod,
                                 output logic pulse_ok);
      logic [15:0] prev;
      lat      = -1;
      busy_cyc = 0;
      hold_ok  = 1'b1;
      pulse_ok = 1'b0;
      @(negedge clk);
      prev      = bus.product;
      bus.a     = a_in;
      bus.b     = b_in;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a     = 8'($urandom);
      bus.b     = 8'($urandom);
      for (int cyc = 1; cyc <= 300; cyc++) begin
         @(negedge clk);
         if (bus.done) begin
            lat = cyc;
            break;
         end
         if (bus.busy) busy_cyc++;
         if (bus.product !== prev) hold_ok = 1'b0;
      end
      prod = bus.product;
      if (lat > 0) begin
         @(negedge clk);
         pulse_ok = !bus.done && !bus.busy;
      end
   endtask

   task automatic run_and_check(input string tag, input logic [7:0] a_in, input logic [7:0] b_in,
                                input logic [15:0] exp_prod, input int exp_lat);
      int          lat;
      int          busy_cyc;
      logic        hold_ok;
      logic [15:0] prod;
      logic        pulse_ok;
      apply_stimulus(a_in, b_in, lat, busy_cyc, hold_ok, prod, pulse_ok);
      check_output({tag, " latency"}, lat, exp_lat);
      check_output({tag, " busy_cycles"}, busy_cyc, exp_lat - 1);
      check_output({tag, " product"}, prod, exp_prod);
      check_output({tag, " product_hold"}, hold_ok, 1);
      check_output({tag, " done_one_cycle"}, pulse_ok, 1);
   endtask

   initial begin
      int          lat;
      int          ra;
      int          rb;
      logic        seen_done;
      logic [15:0] old_prod;

      total_cnt = 0;
      bad_cnt   = 0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;

      vecs[0] = '{a: 8'd7,   b: 8'd5,   exp_product: 16'd35,    exp_latency: 8};
      vecs[1] = '{a: 8'd200, b: 8'd0,   exp_product: 16'd0,     exp_latency: 3};
      vecs[2] = '{a: 8'd0,   b: 8'd9,   exp_product: 16'd0,     exp_latency: 12};
      vecs[3] = '{a: 8'd255, b: 8'd255, exp_product: 16'hFE01,  exp_latency: 258};
      vecs[4] = '{a: 8'd1,   b: 8'd1,   exp_product: 16'd1,     exp_latency: 4};
      vecs[5] = '{a: 8'd15,  b: 8'd17,  exp_product: 16'd255,   exp_latency: 20};
      vecs[6] = '{a: 8'd128, b: 8'd2,   exp_product: 16'd256,   exp_latency: 5};

      // Reset state.
      clear = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_output("reset busy", bus.busy, 0);
      check_output("reset done", bus.done, 0);
      check_output("reset product", bus.product, 0);
      clear = 1'b0;

      // Directed table.
      for (int i = 0; i < 7; i++) begin
         run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                       vecs[i].exp_product, vecs[i].exp_latency);
      end

      // Randomized operands against the arithmetic model.
      for (int i = 0; i < 12; i++) begin
         ra = $urandom_range(0, 255);
         rb = (i % 3 == 0) ? $urandom_range(0, 255) : $urandom_range(0, 40);
         run_and_check($sformatf("rand%0d", i), 8'(ra), 8'(rb), 16'(ra * rb), rb + 3);
      end

      // Known nonzero product before the clear test.
      run_and_check("preclear", 8'd11, 8'd3, 16'd33, 6);

      // Clear between edges in the middle of ADD.
      @(negedge clk);
      bus.a     = 8'd7;
      bus.b     = 8'd50;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      check_output("preclear busy", bus.busy, 1);
      #2;
      clear = 1'b1;
      #1;
      check_output("clear busy", bus.busy, 0);
      check_output("clear done", bus.done, 0);
      check_output("clear product", bus.product, 0);
      @(posedge clk);
      #2;
      clear = 1'b0;
      seen_done = 1'b0;
      for (int cyc = 0; cyc < 80; cyc++) begin
         @(negedge clk);
         if (bus.done || bus.busy) seen_done = 1'b1;
      end
      check_output("no done after clear", seen_done, 0);

      // Start while busy is ignored, then held start launches the next op.
      @(negedge clk);
      bus.a     = 8'd3;
      bus.b     = 8'd4;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      bus.a     = 8'd9;
      bus.b     = 8'd9;
      bus.start = 1'b1;
      lat = -1;
      for (int cyc = 3; cyc <= 40; cyc++) begin
         @(negedge clk);
         if (bus.done) begin
            lat = cyc;
            break;
         end
      end
      check_output("ignored latency", lat, 7);
      check_output("ignored product", bus.product, 12);
      @(negedge clk);
      check_output("held idle busy", bus.busy, 0);
      check_output("held idle done", bus.done, 0);
      old_prod = bus.product;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a     = 8'd0;
      bus.b     = 8'd0;
      lat       = -1;
      seen_done = 1'b1;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         if (bus.done) begin
            lat = cyc;
            break;
         end
         if (bus.product !== 16'd12) seen_done = 1'b0;
      end
      check_output("second op held old", old_prod, 12);
      check_output("second op hold", seen_done, 1);
      check_output("second op latency", lat, 12);
      check_output("second op product", bus.product, 81);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
